alu_top_seq: RTL and testbench

8-bit sequential arithmetic unit performing unsigned add, subtract, multiply and divide on two operand buses. A one-cycle `start` request captures the opcode and operands. The result is presented on `outbus` with a level `done` flag. The block sits between a controller that issues operations and downstream logic that reads the 8-bit result.

---
 rtl/alu_top_seq.sv | 113 +++++++++++
 tb/tb_alu_top_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_top_seq.sv
// 8-bit sequential unsigned ALU: single-cycle ADD/SUB and 8-iteration
// shift-add MUL and restoring DIV, with a level done flag.
module alu_top_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic [7:0] inbus_a,
  input  logic [7:0] inbus_b,
  output logic [7:0] outbus,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic [1:0]  state;
  logic [1:0]  op_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [3:0]  count;

  logic [8:0]  trial;
  logic [8:0]  trial_diff;
  logic        q_bit;
  logic [7:0]  rem_next;

  // Restoring divide step: the dividend shifts out of a_r while quotient
  // bits shift in behind it, so a_r ends up holding the quotient.
  always_comb begin
    trial      = {acc[7:0], a_r[7]};
    trial_diff = trial - {1'b0, b_r};
    q_bit      = (trial >= {1'b0, b_r});
    rem_next   = q_bit ? trial_diff[7:0] : trial[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      op_r   <= 2'b00;
      a_r    <= 8'h00;
      b_r    <= 8'h00;
      acc    <= 16'h0000;
      mcand  <= 16'h0000;
      count  <= 4'd0;
      outbus <= 8'h00;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_r  <= opcode;
            a_r   <= inbus_a;
            b_r   <= inbus_b;
            mcand <= {8'h00, inbus_a};
            acc   <= 16'h0000;
            count <= 4'd0;
            done  <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op_r)
            OP_ADD: begin
              outbus <= a_r + b_r;
              done   <= 1'b1;
              state  <= DONE;
            end
            OP_SUB: begin
              outbus <= a_r - b_r;
              done   <= 1'b1;
              state  <= DONE;
            end
            OP_MUL: begin
              if (count == 4'd8) begin
                outbus <= acc[7:0];
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                if (b_r[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                b_r   <= b_r >> 1;
                count <= count + 4'd1;
              end
            end
            OP_DIV: begin
              if (count == 4'd8) begin
                outbus <= (b_r == 8'h00) ? 8'hFF : a_r;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                acc   <= {8'h00, rem_next};
                a_r   <= {a_r[6:0], q_bit};
                count <= count + 4'd1;
              end
            end
            default: state <= IDLE;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_top_seq.sv
// Directed self-checking bench for alu_top_seq with hand-computed results
// and latencies counted from the edge that samples start.
module tb_alu_top_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] opcode;
  logic [7:0] inbus_a;
  logic [7:0] inbus_b;
  logic [7:0] outbus;
  logic       done;

  int errors = 0;
  int checks = 0;

  alu_top_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .inbus_a (inbus_a),
    .inbus_b (inbus_b),
    .outbus  (outbus),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse, scramble the operands afterwards, then wait for
  // done while checking that outbus holds its old value during EXEC.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] exp_out, input int exp_lat);
    int cycles;
    logic [7:0] held;
    held    = outbus;
    start   = 1'b1;
    opcode  = op;
    inbus_a = a;
    inbus_b = b;
    tick();
    start   = 1'b0;
    inbus_a = ~a;
    inbus_b = 8'h5A;
    opcode  = ~op;
    checkOutput({tag, "_done_clr"}, {15'd0, done}, 16'd0);
    cycles = 0;
    while (!done && cycles < 20) begin
      checkOutput({tag, "_hold"}, {8'd0, outbus}, {8'd0, held});
      tick();
      cycles++;
    end
    checkOutput({tag, "_lat"}, cycles[15:0], exp_lat[15:0]);
    checkOutput({tag, "_out"}, {8'd0, outbus}, {8'd0, exp_out});
  endtask

  initial begin
    int cycles;
    reset   = 1'b0;
    start   = 1'b1;
    opcode  = 2'b00;
    inbus_a = 8'd3;
    inbus_b = 8'd4;

    // Reset held with start high: nothing may launch.
    tick();
    tick();
    checkOutput("rst_out", {8'd0, outbus}, 16'd0);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      tick();
      checkOutput("idle_done", {15'd0, done}, 16'd0);
    end
    checkOutput("idle_out", {8'd0, outbus}, 16'd0);

    applyStimulus("add1", 2'b00, 8'd15,  8'd10,  8'd25,  1);
    applyStimulus("add2", 2'b00, 8'd200, 8'd100, 8'd44,  1);
    applyStimulus("sub1", 2'b01, 8'd20,  8'd8,   8'd12,  1);
    applyStimulus("sub2", 2'b01, 8'd5,   8'd8,   8'd253, 1);
    applyStimulus("mul1", 2'b10, 8'd5,   8'd6,   8'd30,  9);
    applyStimulus("mul2", 2'b10, 8'd20,  8'd20,  8'd144, 9);
    applyStimulus("div1", 2'b11, 8'd25,  8'd5,   8'd5,   9);
    applyStimulus("div2", 2'b11, 8'd7,   8'd9,   8'd0,   9);
    applyStimulus("div0", 2'b11, 8'd9,   8'd0,   8'd255, 9);
    applyStimulus("mul3", 2'b10, 8'd255, 8'd255, 8'd1,   9);
    applyStimulus("div3", 2'b11, 8'd255, 8'd7,   8'd36,  9);

    // done stays high while idle in DONE.
    repeat (3) tick();
    checkOutput("done_level", {15'd0, done}, 16'd1);
    checkOutput("done_outbus", {8'd0, outbus}, 16'd36);

    // A start pulse in the middle of a MUL must be ignored.
    start   = 1'b1;
    opcode  = 2'b10;
    inbus_a = 8'd7;
    inbus_b = 8'd9;
    tick();
    start  = 1'b0;
    cycles = 0;
    repeat (3) begin
      tick();
      cycles++;
    end
    start   = 1'b1;
    opcode  = 2'b00;
    inbus_a = 8'd1;
    inbus_b = 8'd1;
    tick();
    cycles++;
    start = 1'b0;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("midmul_lat", cycles[15:0], 16'd9);
    checkOutput("midmul_out", {8'd0, outbus}, 16'd63);
    tick();
    checkOutput("midmul_stay", {15'd0, done}, 16'd1);

    // Reset in the middle of a DIV aborts it.
    start   = 1'b1;
    opcode  = 2'b11;
    inbus_a = 8'd100;
    inbus_b = 8'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("abort_out", {8'd0, outbus}, 16'd0);
    checkOutput("abort_done", {15'd0, done}, 16'd0);
    repeat (12) begin
      tick();
      checkOutput("abort_nodone", {15'd0, done}, 16'd0);
    end

    // Back-to-back ADDs from DONE: done dips for exactly one cycle.
    applyStimulus("b2b1", 2'b00, 8'd1, 8'd2, 8'd3, 1);
    applyStimulus("b2b2", 2'b00, 8'd3, 8'd4, 8'd7, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
